div_pipe_8bit: RTL and testbench

DIV_PIPE_8BIT -- requirements
Module: div_pipe_8bit

---
 rtl/div_pipe_pkg.sv | 19 +
 rtl/div_pipe_stage.sv | 31 +++
 rtl/div_pipe_8bit.sv | 74 +++++++
 tb/tb_div_pipe_8bit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_pipe_pkg.sv
// Shared constants and the per-stage record for the pipelined restoring divider.
// Optional DIV_ZERO_FLAG_EN adds a divisor-zero bit to each stage record.
package div_pipe_pkg;

    localparam int DIV_SIZE = 8;
    localparam int DIV_LAT  = 2*DIV_SIZE + 2;

    typedef struct packed {
        logic [DIV_SIZE-1:0]   rem;   // partial remainder
        logic [2*DIV_SIZE-1:0] dvd;   // dividend bits still to consume, MSB first
        logic [2*DIV_SIZE-1:0] quo;   // quotient bits produced so far
        logic [DIV_SIZE-1:0]   dsr;   // divisor travels with its operation
        logic                  vld;
`ifdef DIV_ZERO_FLAG_EN
        logic                  zero;
`endif
    } stage_t;

endpackage

// File: rtl/div_pipe_stage.sv
// One restoring-division step: consumes one dividend bit, emits one quotient bit.
// Latency: combinational. Backpressure: none.
// Macro DIV_ZERO_FLAG_EN only affects the record contents carried through.
module div_pipe_stage
    import div_pipe_pkg::*;
(
    input  stage_t cur,
    output stage_t nxt
);

    logic                dvd_msb;
    logic                borrow;
    logic                unused_trial_msb;
    logic [DIV_SIZE-1:0] trial_lo;

    always_comb begin
        nxt     = cur;
        dvd_msb = cur.dvd[2*DIV_SIZE-1];
        // Extra leading bit captures the borrow of the size+1-bit trial subtraction.
        {borrow, unused_trial_msb, trial_lo} = {1'b0, cur.rem, dvd_msb} - {2'b00, cur.dsr};
        nxt.dvd = {cur.dvd[2*DIV_SIZE-2:0], 1'b0};
        if (!borrow) begin
            nxt.rem = trial_lo;
            nxt.quo = {cur.quo[2*DIV_SIZE-2:0], 1'b1};
        end else begin
            nxt.rem = {cur.rem[DIV_SIZE-2:0], dvd_msb};
            nxt.quo = {cur.quo[2*DIV_SIZE-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_pipe_8bit.sv
// Fully pipelined unsigned restoring divider, 2*size-bit dividend by size-bit divisor.
// Latency: DIV_LAT (18) cycles from sampled div_en_in to div_en_out; one op per cycle.
// Backpressure: none, never stalls. DIV_ZERO_FLAG_EN adds the div_zero output.
module div_pipe_8bit
    import div_pipe_pkg::*;
#(
    parameter int size = DIV_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_en_in,
    input  logic [2*size-1:0] div_a,
    input  logic [size-1:0]   div_b,
    output logic              div_en_out,
    output logic [2*size-1:0] div_q,
    output logic [size-1:0]   div_r
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic              div_zero
`endif
);

    localparam int NSTG = 2*size;

    // The vld bits of pipe[0..NSTG] plus div_en_out form the DIV_LAT-bit valid chain.
    stage_t pipe [0:NSTG];
    stage_t step [0:NSTG-1];
    stage_t load;

    always_comb begin
        load = '0;
        if (div_en_in) begin
            load.dvd  = div_a;
            load.dsr  = div_b;
            load.vld  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            load.zero = (div_b == '0);
`endif
        end
    end

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        div_pipe_stage u_stage (
            .cur (pipe[g]),
            .nxt (step[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NSTG; i++) begin
                pipe[i] <= '0;
            end
            div_en_out <= 1'b0;
            div_q      <= '0;
            div_r      <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero   <= 1'b0;
`endif
        end else begin
            pipe[0] <= load;
            for (int i = 0; i < NSTG; i++) begin
                pipe[i+1] <= step[i];
            end
            div_en_out <= pipe[NSTG].vld;
            div_q      <= pipe[NSTG].vld ? pipe[NSTG].quo : '0;
            div_r      <= pipe[NSTG].vld ? pipe[NSTG].rem : '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero   <= pipe[NSTG].vld & pipe[NSTG].zero;
`endif
        end
    end

endmodule

// File: tb/tb_div_pipe_8bit.sv
// Scoreboard bench for div_pipe_8bit: directed vectors, reset flush, random full-rate traffic.
module tb_div_pipe_8bit;
    import div_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_en_in = 1'b0;
    logic [15:0] div_a = '0;
    logic [7:0]  div_b = '0;
    logic        div_en_out;
    logic [15:0] div_q;
    logic [7:0]  div_r;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    exp_t sb[$];

    div_pipe_8bit #(.size(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_en_in  (div_en_in),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_en_out (div_en_out),
        .div_q      (div_q),
        .div_r      (div_r)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero   (div_zero)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation; it is sampled at edge cyc+1 and must emerge after edge cyc+DIV_LAT.
    task automatic send(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] q, input logic [7:0] r);
        exp_t e;
        div_en_in = 1'b1;
        div_a     = a;
        div_b     = b;
        e.due = cyc + DIV_LAT;
        e.q   = q;
        e.r   = r;
        e.z   = (b == 8'd0);
        sb.push_back(e);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            div_en_in = 1'b0;
            div_a     = 16'($urandom);
            div_b     = 8'($urandom);
            tick();
        end
    endtask

    task automatic send_model(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] q;
        logic [15:0] r16;
        if (b == 8'd0) begin
            q   = 16'hFFFF;
            r16 = {8'd0, a[7:0]};
        end else begin
            q   = a / {8'd0, b};
            r16 = a % {8'd0, b};
        end
        send(a, b, q, r16[7:0]);
    endtask

    // Monitor: pops the scoreboard whenever a result is presented, checks zeros in gaps.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (div_en_out) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got q=0x%0h r=0x%0h, expected no result (cycle %0d)",
                                 div_q, div_r, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc, e.due);
                        chk("quotient", {16'd0, div_q}, {16'd0, e.q});
                        chk("remainder", {24'd0, div_r}, {24'd0, e.r});
`ifdef DIV_ZERO_FLAG_EN
                        chk("zero_flag", {31'd0, div_zero}, {31'd0, e.z});
`endif
                    end
                end else begin
                    chk("gap_q", {16'd0, div_q}, 32'd0);
                    chk("gap_r", {24'd0, div_r}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
                    chk("gap_zero", {31'd0, div_zero}, 32'd0);
`endif
                end
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_vld", {31'd0, div_en_out}, 32'd0);
        chk("reset_q", {16'd0, div_q}, 32'd0);
        chk("reset_r", {24'd0, div_r}, 32'd0);
        tick();
        rst_n = 1'b1;

        send(16'd1000, 8'd7, 16'd142, 8'd6);
        idle(20);

        send(16'hFFFF, 8'hFF, 16'd257, 8'd0);
        send(16'hFFFF, 8'h01, 16'hFFFF, 8'd0);
        idle(20);

        send(16'h1234, 8'h00, 16'hFFFF, 8'h34);
        idle(20);

        // 1,0,1,1,0 enable pattern
        send(16'd100, 8'd9, 16'd11, 8'd1);
        idle(1);
        send(16'd65000, 8'd250, 16'd260, 8'd0);
        send(16'd12345, 8'd123, 16'd100, 8'd45);
        idle(1);
        idle(20);

        // Reset with the first of five ops at the output and four still in flight
        send(16'd200, 8'd3, 16'd66, 8'd2);
        send(16'd300, 8'd7, 16'd42, 8'd6);
        send(16'd400, 8'd9, 16'd44, 8'd4);
        send(16'd999, 8'd10, 16'd99, 8'd9);
        send(16'd65535, 8'd2, 16'd32767, 8'd1);
        idle(13);
        chk("pre_reset_vld", {31'd0, div_en_out}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_reset_vld", {31'd0, div_en_out}, 32'd0);
        chk("async_reset_q", {16'd0, div_q}, 32'd0);
        chk("async_reset_r", {24'd0, div_r}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("async_reset_zero", {31'd0, div_zero}, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        idle(25);
        send(16'd77, 8'd5, 16'd15, 8'd2);
        idle(20);

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            send_model(ra, rb);
        end

        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            idle(1);
        end
        chk("drain_pending", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
